// File: rtl/ovdp_audio_pkg.sv
// Shared audio control types: volume width, volume FSM states, full-scale level.
package ovdp_audio_pkg;

    localparam int unsigned VOL_W = 8;
    localparam logic [VOL_W-1:0] VOL_MAX = 8'd255;

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        FADE_OUT = 2'd1,
        MUTED    = 2'd2,
        FADE_IN  = 2'd3
    } vol_state_t;

endpackage

// File: rtl/ramp_tick_gen.sv
// Divides sample_strobe by RAMP_DIV to pace the volume ramp.
module ramp_tick_gen #(
    parameter int unsigned RAMP_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_strobe,
    output logic tick
);

    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Tick on the strobe that completes a divider period.
    always_comb begin
        tick  = sample_strobe && (div_q == DIV_LAST);
        div_d = div_q;
        if (sample_strobe) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
    end

    // Strobe counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/volume_ramp_ctrl.sv
// User target register, 1-LSB volume ramp and soft-mute FSM for the gain stage.
module volume_ramp_ctrl
    import ovdp_audio_pkg::*;
#(
    parameter int unsigned       STEP_SIZE   = 4,
    parameter int unsigned       RAMP_DIV    = 1,
    parameter logic [VOL_W-1:0]  VOL_DEFAULT = 8'd128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_strobe,
    input  logic             vol_up,
    input  logic             vol_down,
    input  logic             mute_toggle,
    input  logic             set_valid,
    input  logic [VOL_W-1:0] set_volume,
    output logic [VOL_W-1:0] volume,
    output logic             mute,
    output logic [VOL_W-1:0] target_volume,
    output logic             ramp_busy
);

    vol_state_t       state_q;
    logic [VOL_W-1:0] volume_q;
    logic [VOL_W-1:0] target_q;
    logic [VOL_W-1:0] target_d;
    logic [VOL_W-1:0] goal;
    logic             mute_q;
    logic             tick;
    logic [VOL_W:0]   sum9;
    logic [VOL_W:0]   diff9;

    ramp_tick_gen #(
        .RAMP_DIV (RAMP_DIV)
    ) u_tick (
        .clk           (clk),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .tick          (tick)
    );

    // Next target: direct load wins, opposing steps cancel, steps saturate.
    always_comb begin
        sum9     = {1'b0, target_q} + (VOL_W+1)'(STEP_SIZE);
        diff9    = {1'b0, target_q} - (VOL_W+1)'(STEP_SIZE);
        target_d = target_q;
        if (set_valid) begin
            target_d = set_volume;
        end else if (vol_up && !vol_down) begin
            target_d = sum9[VOL_W] ? VOL_MAX : sum9[VOL_W-1:0];
        end else if (vol_down && !vol_up) begin
            target_d = diff9[VOL_W] ? '0 : diff9[VOL_W-1:0];
        end
    end

    // Ramp goal follows the mute state; busy while moving or fading.
    always_comb begin
        goal      = ((state_q == FADE_OUT) || (state_q == MUTED)) ? '0 : target_q;
        ramp_busy = (volume_q != goal) || (state_q == FADE_OUT) || (state_q == FADE_IN);
    end

    // Target, ramp and soft-mute FSM; a toggle always beats fade completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FADE_IN;
            volume_q <= '0;
            target_q <= VOL_DEFAULT;
            mute_q   <= 1'b0;
        end else begin
            target_q <= target_d;
            if (tick) begin
                if (volume_q < goal) begin
                    volume_q <= volume_q + VOL_W'(1);
                end else if (volume_q > goal) begin
                    volume_q <= volume_q - VOL_W'(1);
                end
            end
            case (state_q)
                ACTIVE: begin
                    if (mute_toggle) state_q <= FADE_OUT;
                end
                FADE_OUT: begin
                    if (mute_toggle) begin
                        state_q <= FADE_IN;
                    end else if (volume_q == '0) begin
                        state_q <= MUTED;
                        mute_q  <= 1'b1;
                    end
                end
                MUTED: begin
                    if (mute_toggle) begin
                        state_q <= FADE_IN;
                        mute_q  <= 1'b0;
                    end
                end
                FADE_IN: begin
                    if (mute_toggle) begin
                        state_q <= FADE_OUT;
                    end else if (volume_q == target_q) begin
                        state_q <= ACTIVE;
                    end
                end
                default: state_q <= FADE_IN;
            endcase
        end
    end

    assign volume        = volume_q;
    assign mute          = mute_q;
    assign target_volume = target_q;

endmodule

// File: tb/tb_volume_ramp_ctrl.sv
// Directed bench for volume_ramp_ctrl: fade-in, saturation, soft mute, reversal, reset, divider.
module tb_volume_ramp_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_strobe;
    logic       vol_up;
    logic       vol_down;
    logic       mute_toggle;
    logic       set_valid;
    logic [7:0] set_volume;
    logic [7:0] volume;
    logic       mute;
    logic [7:0] target_volume;
    logic       ramp_busy;
    logic [7:0] volume3;
    logic       mute3;
    logic [7:0] target3;
    logic       busy3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    volume_ramp_ctrl #(.STEP_SIZE(4), .RAMP_DIV(1), .VOL_DEFAULT(8'd128)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .vol_up        (vol_up),
        .vol_down      (vol_down),
        .mute_toggle   (mute_toggle),
        .set_valid     (set_valid),
        .set_volume    (set_volume),
        .volume        (volume),
        .mute          (mute),
        .target_volume (target_volume),
        .ramp_busy     (ramp_busy)
    );

    volume_ramp_ctrl #(.STEP_SIZE(4), .RAMP_DIV(3), .VOL_DEFAULT(8'd128)) dut3 (
        .clk           (clk),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .vol_up        (vol_up),
        .vol_down      (vol_down),
        .mute_toggle   (mute_toggle),
        .set_valid     (set_valid),
        .set_volume    (set_volume),
        .volume        (volume3),
        .mute          (mute3),
        .target_volume (target3),
        .ramp_busy     (busy3)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // One strobe edge; outputs are sampled right after it by the caller.
    task automatic strobe_edge();
        sample_strobe = 1'b1;
        step_clk();
        sample_strobe = 1'b0;
    endtask

    task automatic idle3();
        repeat (3) step_clk();
    endtask

    task automatic pulse(input logic up, input logic dn, input logic tog,
                         input logic sv, input logic [7:0] val);
        vol_up = up; vol_down = dn; mute_toggle = tog; set_valid = sv; set_volume = val;
        step_clk();
        vol_up = 1'b0; vol_down = 1'b0; mute_toggle = 1'b0; set_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sample_strobe = 1'b0; vol_up = 1'b0; vol_down = 1'b0;
        mute_toggle = 1'b0; set_valid = 1'b0; set_volume = 8'd0;
        repeat (3) step_clk();
        check("rst_volume", volume, 0);
        check("rst_mute", mute, 0);
        check("rst_target", target_volume, 128);
        check("rst_busy", ramp_busy, 1);
        reset = 1'b0;
        step_clk();

        // 1. power-up fade-in to 128
        for (int i = 1; i <= 128; i++) begin
            strobe_edge();
            check("fadein_vol", volume, i);
            check("fadein_mute", mute, 0);
            idle3();
        end
        check("fadein_done_busy", ramp_busy, 0);

        // 2. target saturation
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'd252);
        check("set_252", target_volume, 252);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check("up_sat1", target_volume, 255);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check("up_sat2", target_volume, 255);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
        check("set_2", target_volume, 2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        check("down_sat1", target_volume, 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        check("down_sat2", target_volume, 0);
        check("vol_held", volume, 128);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'd128);
        check("restore_busy", ramp_busy, 0);

        // 3. soft mute from 128
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        check("fadeout_busy", ramp_busy, 1);
        for (int i = 127; i >= 0; i--) begin
            strobe_edge();
            check("fadeout_vol", volume, i);
            check("fadeout_mute", mute, 0);
            if (i == 0) step_clk(); else idle3();
        end
        check("muted_mute", mute, 1);
        check("muted_busy", ramp_busy, 0);

        // 5. simultaneous updates and target change while muted
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        check("updown_cancel", target_volume, 128);
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
        check("set_beats_up", target_volume, 10);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'd128);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check("muted_up_target", target_volume, 132);
        strobe_edge();
        check("muted_up_vol", volume, 0);
        check("muted_up_mute", mute, 1);
        idle3();
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'd128);

        // unmute: mute drops on the toggle edge, volume still 0
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        check("unmute_mute", mute, 0);
        check("unmute_vol", volume, 0);
        for (int i = 1; i <= 128; i++) begin
            strobe_edge();
            idle3();
        end
        check("refade_vol", volume, 128);
        check("refade_busy", ramp_busy, 0);

        // 4. reverse a fade-out at 64
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 1; i <= 64; i++) begin
            strobe_edge();
            idle3();
        end
        check("rev_at64", volume, 64);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 65; i <= 128; i++) begin
            strobe_edge();
            check("rev_vol", volume, i);
            check("rev_mute", mute, 0);
            idle3();
        end
        check("rev_done_busy", ramp_busy, 0);

        // 6. async reset mid-ramp
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'd200);
        for (int i = 0; i < 3; i++) begin
            strobe_edge();
            idle3();
        end
        check("pre_reset_vol", volume, 131);
        #2 reset = 1'b1;
        #1;
        check("async_rst_vol", volume, 0);
        check("async_rst_mute", mute, 0);
        check("async_rst_target", target_volume, 128);
        step_clk();
        reset = 1'b0;
        step_clk();
        for (int i = 1; i <= 6; i++) begin
            strobe_edge();
            check("div1_vol", volume, i);
            check("div3_vol", volume3, i / 3);
            idle3();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
